// File: rtl/axi_trace_buffer.sv
// axi_trace_buffer: on-chip logic analyser beside the AXI interconnect.
// Registers a bus snapshot every cycle, stores qualified samples in a circular
// buffer, freezes a programmable number of samples after a trigger and
// exposes the frozen trace through a registered read port.
module axi_trace_buffer #(
  parameter int WIDTH = 378,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic             trig_i,
  input  logic             arm_i,
  input  logic [AW-1:0]    post_len_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       state_o,
  output logic [AW-1:0]    trig_addr_o,
  output logic [AW-1:0]    start_addr_o,
  output logic [AW:0]      count_o,
  output logic             done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] s_q;
  logic             v_q;
  logic             t_q;

  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    trig_addr;
  logic [AW-1:0]    post_len_q;
  logic [AW-1:0]    post_cnt;
  logic [WIDTH-1:0] rd_data;
  logic             we;

  logic [WIDTH-1:0] mem [DEPTH];

  // Arm has priority: a qualified sample in the arm cycle is never written.
  assign we = rst_ni && !arm_i && v_q && (state == ARMED || state == POST);

  // Capture stage: snapshot, qualifier and trigger travel together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q <= '0;
      v_q <= 1'b0;
      t_q <= 1'b0;
    end else begin
      s_q <= sample_i;
      v_q <= sample_valid_i;
      t_q <= trig_i;
    end
  end

  // Capture control: arming, write pointer, fill level and trigger tracking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      trig_addr  <= '0;
      post_len_q <= '0;
      post_cnt   <= '0;
    end else if (arm_i) begin
      state      <= ARMED;
      wr_ptr     <= '0;
      count      <= '0;
      post_len_q <= post_len_i;
    end else if (we) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count != FULL) begin
        count <= count + (AW+1)'(1);
      end
      case (state)
        ARMED: begin
          if (t_q) begin
            trig_addr <= wr_ptr;
            if (post_len_q == '0) begin
              state <= DONE;
            end else begin
              state    <= POST;
              post_cnt <= post_len_q;
            end
          end
        end
        POST: begin
          post_cnt <= post_cnt - AW'(1);
          if (post_cnt == AW'(1)) begin
            state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Trace storage: plain write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[wr_ptr] <= s_q;
    end
  end

  // Registered read port; old data is returned on a same-address write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data <= '0;
    end else if (rd_en_i) begin
      rd_data <= mem[rd_addr_i];
    end
  end

  assign rd_data_o    = rd_data;
  assign state_o      = state;
  assign trig_addr_o  = trig_addr;
  assign count_o      = count;
  assign done_o       = (state == DONE);
  assign start_addr_o = (count == FULL) ? wr_ptr : '0;

endmodule

// File: tb/tb_axi_trace_buffer.sv
// Bench for axi_trace_buffer (DEPTH=8, WIDTH=16): directed scenarios plus a
// randomized run, all compared against a sample-sequence reference model.
module tb_axi_trace_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] sample_i;
  logic             sample_valid_i;
  logic             trig_i;
  logic             arm_i;
  logic [AW-1:0]    post_len_i;
  logic             rd_en_i;
  logic [AW-1:0]    rd_addr_i;
  logic [WIDTH-1:0] rd_data_o;
  logic [1:0]       state_o;
  logic [AW-1:0]    trig_addr_o;
  logic [AW-1:0]    start_addr_o;
  logic [AW:0]      count_o;
  logic             done_o;

  axi_trace_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .trig_i         (trig_i),
    .arm_i          (arm_i),
    .post_len_i     (post_len_i),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .state_o        (state_o),
    .trig_addr_o    (trig_addr_o),
    .start_addr_o   (start_addr_o),
    .count_o        (count_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the trace is the sequence of samples accepted since arm.
  int          m_state;      // 0 idle, 1 armed, 2 post, 3 done
  int          m_stored;     // samples accepted since the last arm
  int          m_trig_idx;   // sequence index of the trigger sample
  int          m_plen;
  int          m_post_seen;
  logic [15:0] m_cs;
  bit          m_cv, m_ct;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_rd;
  bit          m_rd_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit arm, input bit valid, input bit trig,
                            input logic [15:0] smp, input bit rden, input int raddr, input int plen);
    if (!rst_n) begin
      m_state = 0; m_stored = 0; m_trig_idx = 0; m_plen = 0; m_post_seen = 0;
      m_cs = '0; m_cv = 0; m_ct = 0;
      m_rd = '0; m_rd_known = 1;
      return;
    end
    if (rden) begin
      m_rd = m_mem[raddr];
      m_rd_known = m_known[raddr];
    end
    if (arm) begin
      m_state = 1; m_stored = 0; m_plen = plen;
    end else if ((m_state == 1 || m_state == 2) && m_cv) begin
      m_mem[m_stored % DEPTH] = m_cs;
      m_known[m_stored % DEPTH] = 1;
      m_stored++;
      if (m_state == 1 && m_ct) begin
        m_trig_idx = m_stored - 1;
        m_post_seen = 0;
        m_state = (m_plen == 0) ? 3 : 2;
      end else if (m_state == 2) begin
        m_post_seen++;
        if (m_post_seen == m_plen) m_state = 3;
      end
    end
    m_cs = smp; m_cv = valid; m_ct = trig;
  endtask

  task automatic step(input bit rst_n, input bit arm, input bit valid, input bit trig,
                      input int plen, input bit rden, input int raddr);
    logic [15:0] smp;
    smp            = 16'(cyc);
    rst_ni         = rst_n;
    arm_i          = arm;
    sample_valid_i = valid;
    trig_i         = trig;
    sample_i       = smp;
    post_len_i     = AW'(plen);
    rd_en_i        = rden;
    rd_addr_i      = AW'(raddr);
    @(posedge clk_i);
    model_edge(rst_n, arm, valid, trig, smp, rden, raddr, plen);
    cyc++;
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("count", 32'(count_o), 32'((m_stored > DEPTH) ? DEPTH : m_stored));
    check("trig_addr", 32'(trig_addr_o), 32'(m_trig_idx % DEPTH));
    check("start_addr", 32'(start_addr_o), 32'((m_stored >= DEPTH) ? (m_stored % DEPTH) : 0));
    check("done", 32'(done_o), 32'(m_state == 3));
    if (m_rd_known) check("rd_data", 32'(rd_data_o), 32'(m_rd));
  endtask

  logic [15:0] prev;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    m_state = 0; m_stored = 0; m_trig_idx = 0; m_rd = '0; m_rd_known = 1;

    // Power-up reset.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("reset_state", 32'(state_o), 0);
    check("reset_rd", 32'(rd_data_o), 0);

    // Reset in the middle of POST.
    step(1, 1, 1, 0, 5, 0, 0);
    step(1, 0, 1, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 5, 0, 0);
    check("pre_rst_post", 32'(state_o), 2);
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_rd", 32'(rd_data_o), 0);

    // No wrap: trigger on third stored sample, two post samples.
    step(1, 1, 1, 0, 2, 0, 0);
    for (int i = 1; i < 9; i++) step(1, 0, 1, (i == 2), 2, 0, 0);
    check("nw_done", 32'(done_o), 1);
    check("nw_count", 32'(count_o), 5);
    check("nw_trig", 32'(trig_addr_o), 2);
    check("nw_start", 32'(start_addr_o), 0);
    for (int a = 0; a < 5; a++) begin
      step(1, 0, 1, 0, 0, 1, a);
      if (a > 0) check("nw_consec", 32'(rd_data_o), 32'(prev + 16'd1));
      prev = rd_data_o;
    end

    // Wrap: trigger on twelfth stored sample, three post samples.
    step(1, 1, 1, 0, 3, 0, 0);
    for (int i = 1; i < 20; i++) step(1, 0, 1, (i == 11), 3, 0, 0);
    check("wr_count", 32'(count_o), 8);
    check("wr_trig", 32'(trig_addr_o), 3);
    check("wr_start", 32'(start_addr_o), 7);
    for (int k = 0; k < DEPTH; k++) begin
      step(1, 0, 1, 0, 0, 1, (7 + k) % DEPTH);
      if (k > 0) check("wr_increasing", 32'(rd_data_o > prev), 1);
      prev = rd_data_o;
    end

    // post_len 0, trigger on the very first stored sample.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    check("p0_done", 32'(done_o), 1);
    check("p0_count", 32'(count_o), 1);
    check("p0_trig", 32'(trig_addr_o), 0);

    // Qualifier toggling; triggers only on invalid cycles.
    step(1, 1, 0, 0, 2, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, (cyc % 2 == 0), (cyc % 2 != 0), 2, 0, 0);
    check("q_armed", 32'(state_o), 1);
    for (int a = 0; a < 4; a++) begin
      step(1, 0, 0, 0, 0, 1, a);
      check("q_even", 32'(rd_data_o[0]), 0);
    end

    // Re-arm while in POST with the trigger also high.
    step(1, 1, 1, 0, 4, 0, 0);
    step(1, 0, 1, 1, 4, 0, 0);
    step(1, 0, 1, 0, 4, 0, 0);
    step(1, 0, 1, 1, 4, 0, 0);
    check("ra_post", 32'(state_o), 2);
    step(1, 1, 1, 1, 4, 1, 0);
    check("ra_state", 32'(state_o), 1);
    check("ra_count", 32'(count_o), 0);
    step(1, 0, 1, 0, 4, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(19) == 0), ($urandom_range(3) != 0),
           ($urandom_range(9) == 0), int'($urandom_range(7)), ($urandom_range(1) == 1),
           int'($urandom_range(7)));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
